// File: rtl/dma_to_sdram_pkg.sv
// Shared types and constants for the frame-RAM to SDRAM write DMA.
package dma_to_sdram_pkg;

    localparam int unsigned SDRAM_AW  = 29;
    localparam int unsigned SDRAM_BCW = 8;
    localparam int unsigned SDRAM_DW  = 64;

    localparam logic [7:0] SDRAM_BYTEEN = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dma_to_sdram_fifo.sv
// Prefetch FIFO between the frame RAM read port and the Avalon write master.
module dma_wr_fifo #(
    parameter int unsigned W     = 48,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage array, written on push only.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap explicitly so DEPTH need not be a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/dma_to_sdram.sv
// Streams frame RAM words to HPS SDRAM as fixed-length Avalon-MM write bursts.
module dma_to_sdram
    import dma_to_sdram_pkg::*;
#(
    parameter int unsigned ADDR_W     = SDRAM_AW,
    parameter int unsigned SRC_AW     = 10,
    parameter int unsigned SRC_W      = 48,
    parameter int unsigned MAX_BURST  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] begin_address,
    input  logic [31:0]       size_buffer,
    output logic              busy,
    output logic              done,
    output logic [SRC_AW-1:0] src_address,
    output logic              src_rd,
    input  logic [SRC_W-1:0]  src_data,
    output logic [ADDR_W-1:0] sdram0_data_address,
    output logic [7:0]        sdram0_data_burstcount,
    output logic              sdram0_data_write,
    output logic [63:0]       sdram0_data_writedata,
    output logic [7:0]        sdram0_data_byteenable,
    input  logic              sdram0_data_waitrequest
);

    localparam int unsigned N_W    = SRC_AW + 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BEAT_W = SDRAM_BCW;
    localparam logic [N_W-1:0] N_MAX = N_W'(2 ** SRC_AW);

    state_t            state;
    logic              start_q;
    logic [ADDR_W-1:0] addr_q;
    logic [SRC_AW-1:0] rd_idx;
    logic [N_W-1:0]    rd_left;
    logic [N_W-1:0]    wr_left;
    logic [BEAT_W-1:0] beats_left;
    logic              rd_vld_q;
    logic [CNT_W-1:0]  fifo_count;
    logic [SRC_W-1:0]  fifo_head;

    logic              start_edge_c;
    logic [N_W-1:0]    n_c;
    logic [BEAT_W-1:0] burst_len_c;
    logic              room_c;
    logic              issue_rd_c;
    logic              accept_c;
    logic              last_beat_c;
    logic              burst_go_c;
    logic              fifo_pop_c;

    // Words returning from the frame RAM land in the prefetch FIFO; the word on the bus is held outside it.
    dma_wr_fifo #(
        .W     (SRC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_vld_q),
        .push_data (src_data),
        .pop       (fifo_pop_c),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Start edge, length clamp, fill-side flow control and burst handshake decode.
    always_comb begin
        start_edge_c = start && !start_q;
        n_c          = (size_buffer > 32'(N_MAX)) ? N_MAX : N_W'(size_buffer);
        burst_len_c  = (wr_left >= N_W'(MAX_BURST)) ? BEAT_W'(MAX_BURST) : BEAT_W'(wr_left);
        room_c       = (32'(fifo_count) + 32'(src_rd) + 32'(rd_vld_q)) < FIFO_DEPTH;
        issue_rd_c   = (state == RUN) && (rd_left != '0) && room_c;
        accept_c     = sdram0_data_write && !sdram0_data_waitrequest;
        last_beat_c  = accept_c && (beats_left == BEAT_W'(1));
        burst_go_c   = (state == RUN) && !sdram0_data_write && (wr_left != '0) &&
                       (32'(fifo_count) >= 32'(burst_len_c));
        fifo_pop_c   = burst_go_c || (accept_c && !last_beat_c);
    end

    // Control FSM with frame RAM reader and Avalon burst master; done fires either on the
    // final accepted beat or, for an empty transfer, on the way out of DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= IDLE;
            start_q                <= 1'b0;
            addr_q                 <= '0;
            rd_idx                 <= '0;
            rd_left                <= '0;
            wr_left                <= '0;
            beats_left             <= '0;
            rd_vld_q               <= 1'b0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            src_address            <= '0;
            src_rd                 <= 1'b0;
            sdram0_data_address    <= '0;
            sdram0_data_burstcount <= '0;
            sdram0_data_write      <= 1'b0;
            sdram0_data_writedata  <= '0;
        end else begin
            start_q  <= start;
            done     <= 1'b0;
            rd_vld_q <= src_rd;
            case (state)
                IDLE: begin
                    src_rd <= 1'b0;
                    if (start_edge_c) begin
                        addr_q  <= begin_address;
                        wr_left <= n_c;
                        busy    <= 1'b1;
                        if (n_c == '0) begin
                            rd_left <= '0;
                            state   <= DONE;
                        end else begin
                            src_rd      <= 1'b1;
                            src_address <= '0;
                            rd_idx      <= SRC_AW'(1);
                            rd_left     <= n_c - N_W'(1);
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    src_rd <= issue_rd_c;
                    if (issue_rd_c) begin
                        src_address <= rd_idx;
                        rd_idx      <= rd_idx + SRC_AW'(1);
                        rd_left     <= rd_left - N_W'(1);
                    end
                    if (burst_go_c) begin
                        sdram0_data_write      <= 1'b1;
                        sdram0_data_address    <= addr_q;
                        sdram0_data_burstcount <= burst_len_c;
                        sdram0_data_writedata  <= SDRAM_DW'(fifo_head);
                        beats_left             <= burst_len_c;
                    end else if (accept_c) begin
                        wr_left    <= wr_left - N_W'(1);
                        beats_left <= beats_left - BEAT_W'(1);
                        if (last_beat_c) begin
                            sdram0_data_write <= 1'b0;
                            addr_q            <= addr_q + ADDR_W'(sdram0_data_burstcount);
                            if (wr_left == N_W'(1)) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= DONE;
                            end
                        end else begin
                            sdram0_data_writedata <= SDRAM_DW'(fifo_head);
                        end
                    end
                end
                DONE: begin
                    src_rd <= 1'b0;
                    done   <= !done;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sdram0_data_byteenable = SDRAM_BYTEEN;

endmodule

// File: doc/dma_to_sdram.md
# dma_to_sdram

Write-direction counterpart of the SDRAM read DMA. Streams a programmed number of 48-bit words out of the 1024-deep frame RAM, zero-extends each to 64 bits, and writes them to HPS SDRAM through the FPGA-to-SDRAM Avalon-MM port as fixed-length write bursts. It is started from the CSR block and used to capture frame-buffer contents back into SDRAM.

## Interface
Parameters:
- ADDR_W, 29, SDRAM word-address width (64-bit words)
- SRC_AW, 10, frame RAM address width
- SRC_W, 48, frame RAM data width
- MAX_BURST, 8, maximum beats per burst (power of two, ≤ 64)
- FIFO_DEPTH, 16, prefetch FIFO depth (≥ 2·MAX_BURST)

Ports:
- clk  in  1  system clock (CLOCK_50 domain); the only clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  CSR start level; a rising edge triggers a transfer
- begin_address  in  ADDR_W  first SDRAM word address
- size_buffer  in  32  number of words to transfer
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the transfer completes
- src_address  out  SRC_AW  frame RAM read address
- src_rd  out  1  frame RAM read strobe
- src_data  in  SRC_W  frame RAM q, valid one cycle after src_rd
- sdram0_data_address  out  ADDR_W  burst start address
- sdram0_data_burstcount  out  8  beats in current burst
- sdram0_data_write  out  1  write request
- sdram0_data_writedata  out  64  {16'h0, word}
- sdram0_data_byteenable  out  8  always 8'hFF
- sdram0_data_waitrequest  in  1  slave stall

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on a rising edge of start, latch begin_address into addr_q and clamp size_buffer to N = min(size_buffer, 2^SRC_AW). If N == 0, go to DONE; otherwise go to RUN. busy rises on the cycle after the edge.
- RUN, fill side:
  - Issue src_rd with src_address = rd_idx while rd_left > 0 and fifo_count + inflight < FIFO_DEPTH.
  - The returned word is pushed into the FIFO one cycle later.
  - rd_idx starts at 0 and increments by 1.
- RUN, write side:
  - When no burst is active, compute len = min(MAX_BURST, wr_left).
  - Start a burst only when fifo_count ≥ len. Then assert write with address = addr_q, burstcount = len, and data = FIFO head.
  - A beat is accepted on write && !waitrequest. Each acceptance pops the FIFO and decrements the beat counter and wr_left.
  - write stays high with no gaps until the final beat of the burst is accepted. After that, addr_q += len.
- When wr_left reaches 0 after an accepted beat, go to DONE.
- DONE: pulse done for one cycle, clear busy, return to IDLE.
- start edges seen while busy are ignored. A start still high after DONE does not retrigger; a new rising edge is required.
- A partial last burst uses len = wr_left (for example, N = 20 with MAX_BURST = 8 gives bursts of 8, 8, 4).
- Arithmetic:
  - addr_q wraps modulo 2^ADDR_W.
  - rd_idx never exceeds N − 1 because of the clamp.
  - The FIFO count is never allowed to overflow; the fill-side condition guarantees this.

## Timing
- Reset values:
  - busy = 0, done = 0, src_rd = 0, src_address = 0.
  - sdram0_data_write = 0, sdram0_data_address = 0, burstcount = 0, writedata = 0.
  - byteenable = 8'hFF. All internal counters are 0, the FIFO is empty, and the state is IDLE.
- Start latency: the first src_rd is asserted 1 cycle after the start edge. The first write is asserted no earlier than len + 2 cycles after the edge.
- While waitrequest = 1:
  - address, burstcount, writedata and write hold stable.
  - Fill-side reads continue if there is FIFO space.
- address and burstcount are significant on the first beat. On later beats they hold the first-beat values.
- Minimum burst throughput with waitrequest = 0 is one beat per cycle. Gap between bursts is at most 1 cycle if the FIFO already holds len words.
- rst_n asserted mid-transfer: all outputs return to reset values immediately, including write dropping mid-burst, and no done is issued.
- done is asserted exactly 1 cycle after the last beat is accepted.

## Structure
- Shared package holds:
  - the state enum: IDLE, RUN, DONE
  - the byteenable constant 8'hFF
  - the default widths for SDRAM address, burstcount and data
- One sub-module, dma_wr_fifo: a synchronous FIFO with SRC_W width and FIFO_DEPTH depth, with push, pop, head, and count ports. It uses the same clk and rst_n.
- The top-level state machine, counters and Avalon master stay in dma_to_sdram.

## Test plan
- N = 16, begin_address = 0x1000, RAM[i] = i, waitrequest = 0 → two bursts at 0x1000 and 0x1008, each burstcount 8. Data is 64'h0…i in order. done pulses once and busy is low afterward.
- N = 20, random waitrequest at 50% → bursts of 8/8/4 at addresses A, A+8, A+16. Signals stay stable during stalls, 20 beats are accepted, and FIFO never overflows.
- size_buffer = 0 → no src_rd and no write. done pulses 2 cycles after the start edge.
- size_buffer = 5000 → clamped to 1024; exactly 128 bursts of 8 are issued, and the last src_address is 1023.
- A second start edge during a transfer of N = 64 → ignored; exactly 64 beats total and a single done.
- rst_n pulled low mid-burst (beat 3 of 8) → write drops asynchronously and all outputs return to reset values. A new start with N = 8 then completes cleanly.
